instr_loader: RTL and testbench

Writes a program into the instruction memory that the core fetches from. The block accepts a stream of 9-bit machine-code words over a valid/ready handshake and issues sequential write strobes starting at address 0, holding the core stalled while it loads. It is the writer for the instruction store, whose read side is addressed by the program counter and returns one 9-bit word per address. It also reports completion and a running XOR checksum so the bench or host can confirm the image.

---
 rtl/instr_loader_pkg.sv | 21 ++
 rtl/instr_loader.sv | 125 ++++++++++++
 tb/tb_instr_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// ============================================================================
// Module   : instr_loader_pkg
// Function : Shared types and constants for the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_loader_pkg;

  localparam int W         = 9;
  localparam int D_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
// Module   : instr_loader
// Function : Streams machine-code words into the instruction store from
//            address 0, stalling the core and tracking an XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int D = D_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [D:0]   len,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         core_hold,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] checksum
);

  localparam logic [D:0] MAX_LEN = {1'b1, {D{1'b0}}};

  state_e       state_q, state_d;
  logic [D-1:0] addr_q, addr_d;
  logic [D:0]   rem_q, rem_d;
  logic [W-1:0] csum_q, csum_d;
  logic         wr_en_q, wr_en_d;
  logic [D-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0] wr_data_q, wr_data_d;
  logic         done_q, done_d;
  logic [D:0]   len_clamped;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          csum_d = '0;
          if (len_clamped == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            rem_d   = len_clamped;
            addr_d  = '0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
          // Wraps to 0 after a full-depth load; never issued with wr_en.
          addr_d    = addr_q + D'(1);
          rem_d     = rem_q - (D+1)'(1);
          csum_d    = csum_q ^ in_data;
          if (rem_q == (D+1)'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign core_hold = busy;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign checksum  = csum_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
// Module   : tb_instr_loader
// Function : Directed self-checking bench for instr_loader (D=12 and D=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:0]  in_data = '0;

  logic        a_start = 1'b0;
  logic [12:0] a_len = '0;
  logic        a_in_ready, a_wr_en, a_core_hold, a_busy, a_done;
  logic [11:0] a_wr_addr;
  logic [8:0]  a_wr_data, a_checksum;

  logic        b_start = 1'b0;
  logic [3:0]  b_len = '0;
  logic        b_in_ready, b_wr_en, b_core_hold, b_busy, b_done;
  logic [2:0]  b_wr_addr;
  logic [8:0]  b_wr_data, b_checksum;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_loader #(.D(12)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .len(a_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .core_hold(a_core_hold), .busy(a_busy), .done(a_done),
    .checksum(a_checksum)
  );

  instr_loader #(.D(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .len(b_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .core_hold(b_core_hold), .busy(b_busy), .done(b_done),
    .checksum(b_checksum)
  );

  // Per-cycle activity log, sampled on the falling edge.
  int cyc = 0;
  int a_addr_q[$];
  int a_data_q[$];
  int a_cyc_q[$];
  int a_done_cnt, a_done_cyc, a_hold_cnt, a_rdy_cnt;
  int b_addr_q[$];
  int b_data_q[$];
  int b_done_cnt, b_rdy_cnt;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (a_wr_en) begin
      a_addr_q.push_back(int'(a_wr_addr));
      a_data_q.push_back(int'(a_wr_data));
      a_cyc_q.push_back(cyc);
    end
    if (a_done) begin
      a_done_cnt = a_done_cnt + 1;
      a_done_cyc = cyc;
    end
    if (a_core_hold) a_hold_cnt = a_hold_cnt + 1;
    if (a_in_ready)  a_rdy_cnt  = a_rdy_cnt + 1;
    if (b_wr_en) begin
      b_addr_q.push_back(int'(b_wr_addr));
      b_data_q.push_back(int'(b_wr_data));
    end
    if (b_done)     b_done_cnt = b_done_cnt + 1;
    if (b_in_ready) b_rdy_cnt  = b_rdy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    a_addr_q.delete(); a_data_q.delete(); a_cyc_q.delete();
    b_addr_q.delete(); b_data_q.delete();
    a_done_cnt = 0; a_done_cyc = -1; a_hold_cnt = 0; a_rdy_cnt = 0;
    b_done_cnt = 0; b_rdy_cnt = 0;
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  logic [8:0] w1 [4] = '{9'b001111110, 9'b001100110, 9'b001111010, 9'b111011110};
  int s;

  initial begin
    clear_log();
    #22;
    // Reset state while rst_n held low
    check("rst_a_outputs", {a_in_ready, a_wr_en, a_core_hold, a_busy, a_done}, 0);
    check("rst_a_addr_data_csum", {a_wr_addr, a_wr_data, a_checksum}, 0);
    check("rst_b_outputs", {b_in_ready, b_wr_en, b_busy, b_done, b_checksum}, 0);
    step();
    rst_n = 1'b1;
    step();

    // Test 1: len=4 back-to-back
    clear_log();
    step(); a_start = 1'b1; a_len = 13'd4; s = cyc;
    step(); a_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w1[i]; step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("t1_nwr", a_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), qget(a_addr_q, i), i);
      check($sformatf("t1_data%0d", i), qget(a_data_q, i), int'(w1[i]));
      check($sformatf("t1_cyc%0d", i), qget(a_cyc_q, i), s + 3 + i);
    end
    check("t1_done_cnt", a_done_cnt, 1);
    check("t1_done_cyc", a_done_cyc, s + 6);
    check("t1_hold_cnt", a_hold_cnt, 5);
    check("t1_rdy_cnt", a_rdy_cnt, 4);
    // 0x07E ^ 0x066 ^ 0x07A ^ 0x1DE
    check("t1_checksum", a_checksum, 9'b110111100);

    // Test 2: len=3 with a 2-cycle in_valid gap between words 1 and 2
    clear_log();
    step(); a_start = 1'b1; a_len = 13'd3; s = cyc;
    step(); a_start = 1'b0;
    in_valid = 1'b1; in_data = 9'h1A5; step();
    in_valid = 1'b1; in_data = 9'h0F0; step();
    in_valid = 1'b0; in_data = 9'h1FF; step(); step();
    in_valid = 1'b1; in_data = 9'h033; step();
    in_valid = 1'b0;
    repeat (3) step();
    check("t2_nwr", a_addr_q.size(), 3);
    check("t2_addr0", qget(a_addr_q, 0), 0);
    check("t2_addr1", qget(a_addr_q, 1), 1);
    check("t2_addr2", qget(a_addr_q, 2), 2);
    check("t2_cyc2", qget(a_cyc_q, 2), s + 7);
    check("t2_done_cyc", a_done_cyc, s + 7);
    check("t2_checksum", a_checksum, 9'h166);

    // Test 3: len=0
    clear_log();
    step(); a_start = 1'b1; a_len = 13'd0; s = cyc;
    step(); a_start = 1'b0; in_valid = 1'b1; in_data = 9'h0AA;
    repeat (3) step();
    in_valid = 1'b0;
    check("t3_nwr", a_addr_q.size(), 0);
    check("t3_done_cnt", a_done_cnt, 1);
    check("t3_done_cyc", a_done_cyc, s + 2);
    check("t3_rdy_cnt", a_rdy_cnt, 0);
    check("t3_checksum", a_checksum, 0);

    // Test 4: D=3, len=9 clamped to 8, nine words offered
    clear_log();
    step(); b_start = 1'b1; b_len = 4'd9;
    step(); b_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = 9'(i * 9 + 1); step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("t4_nwr", b_addr_q.size(), 8);
    check("t4_addr0", qget(b_addr_q, 0), 0);
    check("t4_addr7", qget(b_addr_q, 7), 7);
    check("t4_data7", qget(b_data_q, 7), 64);
    check("t4_rdy_cnt", b_rdy_cnt, 8);
    check("t4_done_cnt", b_done_cnt, 1);
    check("t4_checksum", b_checksum, 9'h078);
    check("t4_a_untouched", a_addr_q.size(), 0);

    // Test 5: asynchronous reset after 2 of 5 words
    clear_log();
    step(); a_start = 1'b1; a_len = 13'd5;
    step(); a_start = 1'b0;
    in_valid = 1'b1; in_data = 9'h111; step();
    in_valid = 1'b1; in_data = 9'h0C3; step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_ctrl_zero", {a_in_ready, a_wr_en, a_core_hold, a_busy, a_done}, 0);
    check("t5_addr_zero", a_wr_addr, 0);
    check("t5_data_zero", a_wr_data, 0);
    check("t5_csum_zero", a_checksum, 0);
    step(); step(); rst_n = 1'b1;
    step();
    check("t5_no_done", a_done_cnt, 0);
    clear_log();
    step(); a_start = 1'b1; a_len = 13'd2;
    step(); a_start = 1'b0;
    in_valid = 1'b1; in_data = 9'h055; step();
    in_valid = 1'b1; in_data = 9'h00F; step();
    in_valid = 1'b0;
    repeat (3) step();
    check("t5_nwr", a_addr_q.size(), 2);
    check("t5_addr0", qget(a_addr_q, 0), 0);
    check("t5_addr1", qget(a_addr_q, 1), 1);
    check("t5_checksum", a_checksum, 9'h05A);

    // Test 6: start re-pulsed during LOAD and during DONE
    clear_log();
    step(); a_start = 1'b1; a_len = 13'd3; s = cyc;
    step(); a_start = 1'b0;
    in_valid = 1'b1; in_data = 9'h001; step();
    a_start = 1'b1; a_len = 13'd1; in_data = 9'h002; step();
    a_start = 1'b0; in_data = 9'h004; step();
    a_start = 1'b1; a_len = 13'd2; in_valid = 1'b0; step();
    a_start = 1'b0;
    repeat (3) step();
    check("t6_nwr", a_addr_q.size(), 3);
    check("t6_addr2", qget(a_addr_q, 2), 2);
    check("t6_done_cnt", a_done_cnt, 1);
    check("t6_done_cyc", a_done_cyc, s + 5);
    check("t6_hold_cnt", a_hold_cnt, 4);
    check("t6_idle_after", a_busy, 0);
    check("t6_checksum", a_checksum, 9'h007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
